// File: rtl/game_pkg.sv
// Shared definitions for the racing game datapath.
// Screen limits, coordinate widths, responder state and knockback
// direction encodings used by the per-car crash responder.
package game_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_KNOCK   = 2'd1,
    ST_RECOVER = 2'd2
  } resp_state_t;

  // POS = right / down (coordinate grows), NEG = left / up (coordinate shrinks).
  // Reset value 0 is POS.
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  // Push away from the other car; a tie pushes in the positive direction.
  function automatic dir_t away_dir(input logic [X_W-1:0] own,
                                    input logic [X_W-1:0] other);
    return (own < other) ? DIR_NEG : DIR_POS;
  endfunction

endpackage

// File: rtl/sat_step.sv
// Combinational +/- STEP on an unsigned coordinate, clamped to [0, MAX].
// Ports:
//   val  in  W  coordinate
//   neg  in  1  1 = subtract STEP, 0 = add STEP
//   res  out W  clamped result
module sat_step #(
  parameter int W    = 10,
  parameter int STEP = 2,
  parameter int MAX  = 639
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // One guard bit so the add cannot wrap before the clamp.
  localparam logic [W:0] STEP_E = STEP[W:0];
  localparam logic [W:0] MAX_E  = MAX[W:0];

  logic [W:0] val_e;
  logic [W:0] sum;
  logic [W:0] dif;

  always_comb begin
    val_e = {1'b0, val};
    sum   = val_e + STEP_E;
    dif   = val_e - STEP_E;
    if (neg) begin
      res = (val_e >= STEP_E) ? dif[W-1:0] : '0;
    end else begin
      res = (sum > MAX_E) ? MAX_E[W-1:0] : sum[W-1:0];
    end
  end

endmodule

// File: rtl/crash_responder.sv
// Per-car crash responder. On an accepted collision it pushes the car away
// from the other car for KNOCK_FRAMES frames (steering locked), then blinks
// the sprite for RECOVER_FRAMES frames while ignoring collisions.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   frame_tick            one-cycle pulse per frame; all stepping happens on it
//   game_en               race running; low forces IDLE next cycle
//   ifcollision           collision level (sampled on frame_tick)
//   x_in/y_in             own car centre
//   x_other/y_other       other car centre
//   push_valid/x/y        one-cycle load of an overriding position
//   ctrl_lock             steering ignored
//   invuln                collisions ignored
//   visible               sprite draw enable
//   crash_pulse           one-cycle pulse per accepted crash
//   crash_cnt             accepted crashes, saturating at 255
module crash_responder
  import game_pkg::*;
#(
  parameter int KNOCK_FRAMES   = 16,
  parameter int RECOVER_FRAMES = 60,
  parameter int BLINK_FRAMES   = 8,
  parameter int KNOCK_STEP     = 2,
  parameter int X_MAX          = SCREEN_X_MAX,
  parameter int Y_MAX          = SCREEN_Y_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_tick,
  input  logic           game_en,
  input  logic           ifcollision,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [X_W-1:0] x_other,
  input  logic [Y_W-1:0] y_other,
  output logic           push_valid,
  output logic [X_W-1:0] push_x,
  output logic [Y_W-1:0] push_y,
  output logic           ctrl_lock,
  output logic           invuln,
  output logic           visible,
  output logic           crash_pulse,
  output logic [7:0]     crash_cnt
);

  localparam int CNT_MAX = (KNOCK_FRAMES > RECOVER_FRAMES) ? KNOCK_FRAMES : RECOVER_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BL_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] KNOCK_LOAD   = CNT_W'(KNOCK_FRAMES);
  localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [BL_W-1:0]  BLINK_LAST   = BL_W'(BLINK_FRAMES - 1);

  resp_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BL_W-1:0]  blink_q, blink_d;
  logic             vis_q, vis_d;
  dir_t             dir_x_q, dir_x_d;
  dir_t             dir_y_q, dir_y_d;
  logic             push_valid_q, push_valid_d;
  logic [X_W-1:0]   push_x_q, push_x_d;
  logic [Y_W-1:0]   push_y_q, push_y_d;
  logic             crash_pulse_q, crash_pulse_d;
  logic [7:0]       crash_cnt_q, crash_cnt_d;

  logic [X_W-1:0]   step_x;
  logic [Y_W-1:0]   step_y;
  logic [X_W-1:0]   y_in_e, y_other_e;

  // Pushes are computed from the car's current position each tick, so the
  // position register remains the single source of truth.
  sat_step #(.W(X_W), .STEP(KNOCK_STEP), .MAX(X_MAX)) u_step_x (
    .val (x_in),
    .neg (dir_x_q == DIR_NEG),
    .res (step_x)
  );

  sat_step #(.W(Y_W), .STEP(KNOCK_STEP), .MAX(Y_MAX)) u_step_y (
    .val (y_in),
    .neg (dir_y_q == DIR_NEG),
    .res (step_y)
  );

  assign y_in_e    = {{(X_W-Y_W){1'b0}}, y_in};
  assign y_other_e = {{(X_W-Y_W){1'b0}}, y_other};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      blink_q       <= '0;
      vis_q         <= 1'b1;
      dir_x_q       <= DIR_POS;
      dir_y_q       <= DIR_POS;
      push_valid_q  <= 1'b0;
      push_x_q      <= '0;
      push_y_q      <= '0;
      crash_pulse_q <= 1'b0;
      crash_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      blink_q       <= blink_d;
      vis_q         <= vis_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      push_valid_q  <= push_valid_d;
      push_x_q      <= push_x_d;
      push_y_q      <= push_y_d;
      crash_pulse_q <= crash_pulse_d;
      crash_cnt_q   <= crash_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    blink_d       = blink_q;
    vis_d         = vis_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    push_valid_d  = 1'b0;
    push_x_d      = push_x_q;
    push_y_d      = push_y_q;
    crash_pulse_d = 1'b0;
    crash_cnt_d   = crash_cnt_q;

    if (!game_en) begin
      // Abort anything in flight; crash_cnt survives.
      state_d = ST_IDLE;
      cnt_d   = '0;
      blink_d = '0;
      vis_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_tick && ifcollision) begin
            state_d       = ST_KNOCK;
            dir_x_d       = away_dir(x_in, x_other);
            dir_y_d       = away_dir(y_in_e, y_other_e);
            cnt_d         = KNOCK_LOAD;
            crash_pulse_d = 1'b1;
            if (crash_cnt_q != 8'hFF) crash_cnt_d = crash_cnt_q + 8'd1;
          end
        end
        ST_KNOCK: begin
          if (frame_tick) begin
            push_valid_d = 1'b1;
            push_x_d     = step_x;
            push_y_d     = step_y;
            cnt_d        = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = ST_RECOVER;
              cnt_d   = RECOVER_LOAD;
              blink_d = '0;
              vis_d   = 1'b0;
            end
          end
        end
        ST_RECOVER: begin
          // ifcollision is deliberately not looked at here, including on
          // the final tick, so a new crash needs a later tick in IDLE.
          if (frame_tick) begin
            cnt_d = cnt_q - CNT_ONE;
            if (blink_q == BLINK_LAST) begin
              blink_d = '0;
              vis_d   = ~vis_q;
            end else begin
              blink_d = blink_q + 1'b1;
            end
            if (cnt_q == CNT_ONE) begin
              state_d = ST_IDLE;
              vis_d   = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          vis_d   = 1'b1;
        end
      endcase
    end
  end

  assign push_valid  = push_valid_q;
  assign push_x      = push_x_q;
  assign push_y      = push_y_q;
  assign crash_pulse = crash_pulse_q;
  assign crash_cnt   = crash_cnt_q;
  assign visible     = vis_q;
  assign ctrl_lock   = (state_q == ST_KNOCK);
  assign invuln      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crash_responder.sv
module tb_crash_responder;

  localparam int KF = 16;
  localparam int RF = 60;
  localparam int BF = 8;
  localparam int KS = 2;
  localparam int XM = 639;
  localparam int YM = 479;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_en = 1'b0;
  logic       ifcollision = 1'b0;
  logic [9:0] x_in = '0;
  logic [8:0] y_in = '0;
  logic [9:0] x_other = '0;
  logic [8:0] y_other = '0;
  logic       push_valid;
  logic [9:0] push_x;
  logic [8:0] push_y;
  logic       ctrl_lock, invuln, visible, crash_pulse;
  logic [7:0] crash_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model: pushes left, recovery ticks done, expected outputs
  int knock_left, rec_done, e_cnt, e_px, e_py;
  bit in_rec, go_left, go_up, e_pv, e_cp;

  always #5 clk = ~clk;

  crash_responder #(
    .KNOCK_FRAMES(KF), .RECOVER_FRAMES(RF), .BLINK_FRAMES(BF),
    .KNOCK_STEP(KS), .X_MAX(XM), .Y_MAX(YM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_en(game_en),
    .ifcollision(ifcollision), .x_in(x_in), .y_in(y_in),
    .x_other(x_other), .y_other(y_other),
    .push_valid(push_valid), .push_x(push_x), .push_y(push_y),
    .ctrl_lock(ctrl_lock), .invuln(invuln), .visible(visible),
    .crash_pulse(crash_pulse), .crash_cnt(crash_cnt)
  );

  task automatic chk(string tag, int got, int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    knock_left = 0; rec_done = 0; in_rec = 0; go_left = 0; go_up = 0;
    e_cnt = 0; e_px = 0; e_py = 0; e_pv = 0; e_cp = 0;
  endtask

  // One clock edge of behaviour, stated in frames and pixels.
  task automatic model_edge();
    e_pv = 0;
    e_cp = 0;
    if (!game_en) begin
      knock_left = 0;
      in_rec     = 0;
    end else if (frame_tick) begin
      if (knock_left > 0) begin
        e_pv = 1;
        e_px = go_left ? ((int'(x_in) - KS < 0) ? 0 : int'(x_in) - KS)
                       : ((int'(x_in) + KS > XM) ? XM : int'(x_in) + KS);
        e_py = go_up   ? ((int'(y_in) - KS < 0) ? 0 : int'(y_in) - KS)
                       : ((int'(y_in) + KS > YM) ? YM : int'(y_in) + KS);
        knock_left--;
        if (knock_left == 0) begin
          in_rec   = 1;
          rec_done = 0;
        end
      end else if (in_rec) begin
        rec_done++;
        if (rec_done == RF) in_rec = 0;
      end else if (ifcollision) begin
        knock_left = KF;
        go_left    = (x_in < x_other);
        go_up      = (y_in < y_other);
        e_cp       = 1;
        if (e_cnt < 255) e_cnt++;
      end
    end
  endtask

  task automatic check_all(string tag);
    int e_vis;
    e_vis = in_rec ? ((rec_done / BF) % 2) : 1;
    chk({tag, ".push_valid"},  int'(push_valid),  int'(e_pv));
    chk({tag, ".push_x"},      int'(push_x),      e_px);
    chk({tag, ".push_y"},      int'(push_y),      e_py);
    chk({tag, ".crash_pulse"}, int'(crash_pulse), int'(e_cp));
    chk({tag, ".crash_cnt"},   int'(crash_cnt),   e_cnt);
    chk({tag, ".ctrl_lock"},   int'(ctrl_lock),   (knock_left > 0) ? 1 : 0);
    chk({tag, ".invuln"},      int'(invuln),      (knock_left > 0 || in_rec) ? 1 : 0);
    chk({tag, ".visible"},     int'(visible),     e_vis);
  endtask

  task automatic step(string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic tick(string tag);
    frame_tick = 1'b1;
    step(tag);
    frame_tick = 1'b0;
    step(tag);
  endtask

  initial begin
    model_reset();
    // 1: reset, then collision level with no ticks
    repeat (3) step("rst");
    rst_n = 1'b1;
    game_en = 1'b1;
    ifcollision = 1'b1;
    repeat (100) step("notick");
    chk("notick.cnt0", int'(crash_cnt), 0);

    // 2: directed crash, pushes tracked back into the position
    x_in = 10'd100; y_in = 9'd200; x_other = 10'd150; y_other = 9'd180;
    frame_tick = 1'b1;
    step("crash1");
    frame_tick = 1'b0;
    chk("crash1.pulse", int'(crash_pulse), 1);
    chk("crash1.cnt", int'(crash_cnt), 1);
    step("crash1");
    ifcollision = 1'b0;
    for (int i = 0; i < KF; i++) begin
      frame_tick = 1'b1;
      step("knock");
      frame_tick = 1'b0;
      if (i == 0) begin
        chk("knock.x0", int'(push_x), 98);
        chk("knock.y0", int'(push_y), 202);
      end
      x_in = e_px[9:0];
      y_in = e_py[8:0];
      step("knock");
    end
    chk("knock.xend", int'(push_x), 100 - 2 * KF);
    chk("knock.yend", int'(push_y), 200 + 2 * KF);
    chk("rec.lock", int'(ctrl_lock), 0);
    chk("rec.inv", int'(invuln), 1);

    // 4: recovery blink with collisions ignored
    ifcollision = 1'b1;
    for (int i = 0; i < RF; i++) begin
      tick("recover");
      if (i < RF - 1) chk("recover.vis", int'(visible), ((i + 1) / BF) % 2);
    end
    chk("rec_end.vis", int'(visible), 1);
    chk("rec_end.inv", int'(invuln), 0);
    chk("rec_end.cnt", int'(crash_cnt), 1);
    tick("crash2");
    chk("crash2.cnt", int'(crash_cnt), 2);

    // 5: drop game_en mid-knock
    repeat (5) tick("knock2");
    game_en = 1'b0;
    step("abort");
    chk("abort.lock", int'(ctrl_lock), 0);
    chk("abort.inv", int'(invuln), 0);
    chk("abort.vis", int'(visible), 1);
    chk("abort.cnt", int'(crash_cnt), 2);
    tick("abort");
    game_en = 1'b1;

    // 3: clamps
    x_in = 10'd1; x_other = 10'd50; y_in = 9'd1; y_other = 9'd100;
    tick("clamp_lo");
    tick("clamp_lo");
    chk("clamp_lo.x", int'(push_x), 0);
    chk("clamp_lo.y", int'(push_y), 0);
    game_en = 1'b0; step("clamp"); game_en = 1'b1;
    x_in = 10'd638; x_other = 10'd10; y_in = 9'd478; y_other = 9'd0;
    tick("clamp_hi");
    tick("clamp_hi");
    chk("clamp_hi.x", int'(push_x), 639);
    chk("clamp_hi.y", int'(push_y), 479);
    game_en = 1'b0; step("clamp"); game_en = 1'b1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      frame_tick  = ($urandom_range(0, 2) == 0);
      ifcollision = ($urandom_range(0, 3) != 0);
      game_en     = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) begin
        x_in    = 10'($urandom_range(0, XM));
        y_in    = 9'($urandom_range(0, YM));
        x_other = 10'($urandom_range(0, XM));
        y_other = 9'($urandom_range(0, YM));
      end
      step("rand");
    end
    frame_tick = 1'b0;
    game_en = 1'b0;
    step("rand");
    game_en = 1'b1;

    // 6: saturate the counter with quick crash/abort pairs
    ifcollision = 1'b1;
    for (int i = 0; i < 300; i++) begin
      frame_tick = 1'b1;
      step("sat");
      frame_tick = 1'b0;
      game_en = 1'b0;
      step("sat");
      game_en = 1'b1;
    end
    chk("sat.cnt", int'(crash_cnt), 255);

    // async reset mid-RECOVER
    ifcollision = 1'b1;
    x_in = 10'd300; y_in = 9'd200; x_other = 10'd300; y_other = 9'd200;
    tick("pre_rst");
    ifcollision = 1'b0;
    repeat (KF + 5) tick("pre_rst");
    chk("pre_rst.inv", int'(invuln), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.inv", int'(invuln), 0);
    chk("async_rst.cnt", int'(crash_cnt), 0);
    step("rst_hold");
    rst_n = 1'b1;
    repeat (3) step("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
